timer_device: RTL and testbench

//   Memory-mapped 16-bit down-counting timer; a peer bus device beside the UART behind
//   the top-level device decoder. Decoder supplies write_enable (already gated by target

---
 rtl/timer_device.sv | 149 ++++++++++++++
 tb/tb_timer_device.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// Memory-mapped 16-bit prescaled down-counting timer with one-shot/periodic
// reload, sticky expiry flag and level interrupt.
module timer_device #(
    parameter logic [15:0] DEVICE_ID   = 16'h0200,
    parameter logic [15:0] DEVICE_TYPE = 16'h0004
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        write_enable,
    input  logic        control,
    input  logic [7:0]  address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        irq
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    // Data-space word addresses
    localparam logic [7:0] A_CTRL     = 8'd0;
    localparam logic [7:0] A_PRESCALE = 8'd1;
    localparam logic [7:0] A_RELOAD   = 8'd2;
    localparam logic [7:0] A_COUNT    = 8'd3;
    localparam logic [7:0] A_STATUS   = 8'd4;

    // CTRL bit positions
    localparam int unsigned B_EN       = 0;
    localparam int unsigned B_PERIODIC = 1;
    localparam int unsigned B_IE       = 2;

    logic [CW-1:0] ctrl_q,     ctrl_d;
    logic [DW-1:0] prescale_q, prescale_d;
    logic [DW-1:0] reload_q,   reload_d;
    logic [DW-1:0] count_q,    count_d;
    logic [DW-1:0] pcnt_q,     pcnt_d;
    logic          expired_q,  expired_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          irq_q,      irq_d;

    logic wr_data_c;
    logic tick_c;
    logic expire_c;

    // Next-state computation for all registers, defaults first
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        expired_d  = expired_q;
        data_out_d = '0;

        wr_data_c = write_enable && !control;
        tick_c    = ctrl_q[B_EN] && (pcnt_q == prescale_q);
        // A COUNT write in the tick cycle suppresses both decrement and expiry
        expire_c  = tick_c && (count_q == '0) && !(wr_data_c && address == A_COUNT);

        // Read mux sees pre-write register values
        if (control) begin
            case (address)
                8'd0:    data_out_d = DEVICE_ID;
                8'd1:    data_out_d = DEVICE_TYPE;
                8'd2:    data_out_d = DW'(expired_q);
                default: data_out_d = '0;
            endcase
        end else begin
            case (address)
                A_CTRL:     data_out_d = DW'(ctrl_q);
                A_PRESCALE: data_out_d = prescale_q;
                A_RELOAD:   data_out_d = reload_q;
                A_COUNT:    data_out_d = count_q;
                A_STATUS:   data_out_d = DW'(expired_q);
                default:    data_out_d = '0;
            endcase
        end

        // Countdown and reload on prescaler tick
        if (tick_c) begin
            if (count_q != '0) begin
                count_d = count_q - DW'(1);
            end else if (ctrl_q[B_PERIODIC]) begin
                count_d = reload_q;
            end else begin
                count_d    = '0;
                ctrl_d[B_EN] = 1'b0;
            end
        end

        // Bus writes take priority over timer-side updates
        if (wr_data_c) begin
            case (address)
                A_CTRL:     ctrl_d     = data_in[CW-1:0];
                A_PRESCALE: prescale_d = data_in;
                A_RELOAD:   reload_d   = data_in;
                A_COUNT:    count_d    = data_in;
                default:    ;
            endcase
        end

        // Sticky flag: set beats write-1-to-clear
        if (wr_data_c && address == A_STATUS && data_in[0]) begin
            expired_d = 1'b0;
        end
        if (expire_c) begin
            expired_d = 1'b1;
        end

        // Prescaler: free-runs only while enabled, restarts on PRESCALE write
        if (!ctrl_q[B_EN] || tick_c) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + DW'(1);
        end
        if (!ctrl_d[B_EN] || (wr_data_c && address == A_PRESCALE)) begin
            pcnt_d = '0;
        end

        irq_d = expired_d && ctrl_d[B_IE];
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            expired_q  <= 1'b0;
            data_out_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            expired_q  <= expired_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_timer_device.sv
// Randomized plus directed bench for timer_device against a cycle model.
module tb_timer_device;

    logic        clock;
    logic        reset_n;
    logic        write_enable;
    logic        control;
    logic [7:0]  address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        irq;

    int checks_q;
    int errors_q;

    // Reference state
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre, m_rel, m_cnt, m_pcnt, m_dout;
    logic        m_exp, m_irq;

    timer_device dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .control      (control),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .irq          (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_pre = '0; m_rel = '0; m_cnt = '0; m_pcnt = '0;
        m_exp = 1'b0; m_dout = '0; m_irq = 1'b0;
    endtask

    // One clock of timer behaviour, described from the register-map rules
    task automatic model_step(input logic we, input logic ctl, input logic [7:0] a,
                              input logic [15:0] d);
        logic [15:0] rd;
        logic        running, tick, hit_zero, wr_cnt;
        logic [2:0]  n_ctrl;
        logic [15:0] n_cnt, n_pcnt;
        logic        n_exp;
        rd = 16'h0;
        if (ctl) begin
            if (a == 0) rd = 16'h0200;
            else if (a == 1) rd = 16'h0004;
            else if (a == 2) rd = {15'h0, m_exp};
        end else begin
            if (a == 0) rd = {13'h0, m_ctrl};
            else if (a == 1) rd = m_pre;
            else if (a == 2) rd = m_rel;
            else if (a == 3) rd = m_cnt;
            else if (a == 4) rd = {15'h0, m_exp};
        end
        running  = m_ctrl[0];
        tick     = running && (m_pcnt == m_pre);
        wr_cnt   = we && !ctl && a == 3;
        hit_zero = tick && m_cnt == 0 && !wr_cnt;

        n_ctrl = m_ctrl;
        n_cnt  = m_cnt;
        if (tick && m_cnt != 0) n_cnt = m_cnt - 16'd1;
        if (hit_zero) begin
            if (m_ctrl[1]) n_cnt = m_rel;
            else n_ctrl[0] = 1'b0;
        end
        if (wr_cnt) n_cnt = d;
        if (we && !ctl && a == 0) n_ctrl = d[2:0];

        n_pcnt = (running && !tick) ? m_pcnt + 16'd1 : 16'd0;
        if (!n_ctrl[0] || (we && !ctl && a == 1)) n_pcnt = 16'd0;

        n_exp = hit_zero || (m_exp && !(we && !ctl && a == 4 && d[0]));

        if (we && !ctl && a == 1) m_pre = d;
        if (we && !ctl && a == 2) m_rel = d;
        m_ctrl = n_ctrl;
        m_cnt  = n_cnt;
        m_pcnt = n_pcnt;
        m_exp  = n_exp;
        m_dout = rd;
        m_irq  = n_exp && n_ctrl[2];
    endtask

    // Drive one bus cycle, advance the model, compare outputs after the edge
    task automatic bus(input logic we, input logic ctl, input logic [7:0] a,
                       input logic [15:0] d);
        @(negedge clock);
        write_enable = we; control = ctl; address = a; data_in = d;
        @(posedge clock);
        model_step(we, ctl, a, d);
        #1;
        check("data_out", data_out, m_dout);
        check("irq", {15'h0, irq}, {15'h0, m_irq});
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic ctl, input logic [7:0] a);
        bus(1'b0, ctl, a, 16'h0);
    endtask

    logic [15:0] seq [5];

    initial begin
        checks_q = 0; errors_q = 0;
        write_enable = 0; control = 0; address = 0; data_in = 0;
        reset_n = 0;
        model_reset();
        #12;
        check("reset data_out", data_out, 16'h0);
        check("reset irq", {15'h0, irq}, 16'h0);
        @(negedge clock);
        reset_n = 1;

        // Identification words
        rd(1'b1, 8'd0);
        check("dev id", data_out, 16'h0200);
        rd(1'b1, 8'd1);
        check("dev type", data_out, 16'h0004);

        // Periodic, prescale 0, reload 3: period of 4
        wr(8'd1, 16'd0); wr(8'd2, 16'd3); wr(8'd3, 16'd3); wr(8'd0, 16'h0003);
        seq[0] = 3; seq[1] = 2; seq[2] = 1; seq[3] = 0; seq[4] = 3;
        for (int i = 0; i < 5; i++) begin
            rd(1'b0, 8'd3);
            check("periodic count", data_out, seq[i]);
            check("periodic irq", {15'h0, irq}, 16'h0);
        end
        rd(1'b1, 8'd2);
        check("periodic expired", data_out, 16'h1);

        // One-shot, prescale 1, count 2, IE
        wr(8'd0, 16'h0); wr(8'd4, 16'h1); wr(8'd1, 16'd1); wr(8'd3, 16'd2);
        wr(8'd0, 16'h0005);
        for (int i = 0; i < 5; i++) begin
            rd(1'b0, 8'd4);
            check("oneshot pre irq", {15'h0, irq}, 16'h0);
        end
        rd(1'b0, 8'd4);
        check("oneshot irq", {15'h0, irq}, 16'h1);
        rd(1'b0, 8'd0);
        check("oneshot ctrl", data_out, 16'h0004);
        rd(1'b0, 8'd3);
        check("oneshot count", data_out, 16'h0);
        wr(8'd4, 16'h1);
        check("irq cleared", {15'h0, irq}, 16'h0);

        // Clear colliding with expiry: set wins
        wr(8'd1, 16'd0); wr(8'd2, 16'd2); wr(8'd3, 16'd2); wr(8'd0, 16'h0003);
        rd(1'b0, 8'd3); rd(1'b0, 8'd3);
        wr(8'd4, 16'h1);
        rd(1'b0, 8'd4);
        check("clear vs set", data_out, 16'h1);
        // COUNT write on a tick cycle: no decrement
        wr(8'd3, 16'h00FF);
        rd(1'b0, 8'd3);
        check("count write wins", data_out, 16'h00FF);
        wr(8'd0, 16'h0);

        // Asynchronous reset mid-count
        wr(8'd4, 16'h1); wr(8'd3, 16'h0010); wr(8'd0, 16'h0005);
        rd(1'b0, 8'd3);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check("async rst data_out", data_out, 16'h0);
        check("async rst irq", {15'h0, irq}, 16'h0);
        @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            rd(1'b0, 8'(i));
            check("post reset reg", data_out, 16'h0);
        end
        for (int i = 0; i < 20; i++) rd(1'b1, 8'd2);
        check("no expiry after reset", data_out, 16'h0);

        // Unmapped locations
        wr(8'd1, 16'h1234);
        bus(1'b1, 1'b0, 8'd7, 16'hFFFF);
        bus(1'b1, 1'b1, 8'd5, 16'hFFFF);
        bus(1'b1, 1'b1, 8'd0, 16'hFFFF);
        rd(1'b0, 8'd7);
        check("unmapped data 7", data_out, 16'h0);
        rd(1'b1, 8'd5);
        check("unmapped ctl 5", data_out, 16'h0);
        rd(1'b0, 8'd1);
        check("prescale kept", data_out, 16'h1234);
        rd(1'b1, 8'd0);
        check("id kept", data_out, 16'h0200);
        wr(8'd1, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  a;
            logic [15:0] d;
            logic        ctl, we;
            a   = 8'($urandom_range(0, 7));
            ctl = 1'($urandom_range(0, 3) == 0);
            we  = 1'($urandom_range(0, 5) == 0);
            d   = (a == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 5));
            if (a == 0 && !ctl && we && $urandom_range(0, 1) == 1) d = 16'h0007;
            bus(we, ctl, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
        $finish;
    end

endmodule
